timestamp_capture: RTL and testbench
====================================

// Module: timestamp_capture
// PURPOSE
//  Consumes the free-running 64-bit ns Timer bus and timestamps edges on an
//  asynchronous Event input. Stamps queue in a DEPTH-entry FIFO and drain via
//  valid/ready to the host/logging side. Sits beside the Timer, one per pin.
// PARAMETERS
//  INC          20  Timer increment per Clk [ns]; used for latency compensation
//  SYNC_STAGES   2  Event synchroniser flops, >=2
//  DEPTH         8  FIFO entries, power of two, >=2
//  CAPTURE_RISE  1  1 = timestamp rising edges of Event
//  CAPTURE_FALL  0  1 = timestamp falling edges of Event
// PORTS
//  Clk          in   1   system clock, same clock as the Timer
//  Reset        in   1   synchronous, active-high reset
//  Timer        in   64  current time [ns]
//  Event        in   1   asynchronous event pin
//  Clear        in   1   1-cycle pulse: clears Overflow and Dropped
//  Stamp        out  64  timestamp at FIFO head [ns]
//  Stamp_Edge   out  1   1 = rising edge, 0 = falling edge (head entry)
//  Stamp_Valid  out  1   head entry valid
//  Stamp_Ready  in   1   consumer accepts head when Valid & Ready
//  Overflow     out  1   sticky: at least one event dropped
//  Dropped      out  16  dropped-event count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (sampled high at Clk): FIFO emptied, Stamp=0, Stamp_Edge=0,
//   Stamp_Valid=0, Overflow=0, Dropped=0, sync chain=0.
//   Reset mid-operation discards all queued stamps.
//  Edge detection is masked for SYNC_STAGES+1 cycles after Reset deasserts
//   (no spurious edge if Event is already high).
//  Sync: Event -> SYNC_STAGES flops -> s; prev <= s each cycle.
//  Detect cycle: s!=prev and the matching CAPTURE_* is 1. In that cycle the
//   written stamp = Timer - SYNC_STAGES*INC, mod 2^64 (wraps, no saturation).
//  Pulses shorter than ~2 Clk may be missed; this is not an error.
//  Write: in the detect cycle, if not full, or full with a pop in the same
//   cycle. Pop: Stamp_Valid & Stamp_Ready.
//  Full with no pop: event dropped, Overflow<=1, Dropped+1 (saturating).
//  Clear & drop in the same cycle: drop wins (Overflow=1, Dropped=1).
//  Clear alone: Overflow<=0, Dropped<=0.
//  Latency: Stamp/Stamp_Valid are registered. An entry written at cycle k is
//   visible at k+1 when the FIFO was empty (first-word fall-through).
//  Stamp/Stamp_Edge hold stable while Valid & !Ready. Values are don't-care
//   when Valid=0, but the last head is retained.
//  Empty: Stamp_Valid=0; Ready is ignored.
//  Simultaneous pop and write when not empty: occupancy unchanged, order kept.
//  Pointers are log2(DEPTH)+1 bits; full/empty from MSB compare; wrap is free.
// TESTING
//  1 Reset with Event=1 held, release -> no stamp for >=SYNC_STAGES+1 cycles,
//    Stamp_Valid=0.
//  2 Timer=1000 (INC=20), rise on Event, Ready=1 -> one stamp;
//    Stamp = Timer_at_detect - 40, Stamp_Edge=1, Valid high 1 cycle.
//  3 Ready=0, 10 rising edges, DEPTH=8 -> 8 stamps queued, Overflow=1,
//    Dropped=2. Drain -> 8 stamps in order, increasing.
//  4 FIFO full, pop and detect in the same cycle -> write accepted,
//    Dropped unchanged, count stays 8.
//  5 Timer=64'hFFFF_FFFF_FFFF_FFF0, edge -> stamp wraps mod 2^64.
//    CAPTURE_FALL=1 -> falling edge gives Stamp_Edge=0.
//  6 Dropped forced to 16'hFFFF, overflow again -> stays FFFF.
//    Clear -> 0. Clear coincident with a drop -> Dropped=1.

Source files
------------

// File: rtl/timestamp_capture.sv
// Timestamps synchronised edges of an asynchronous Event pin against the Timer bus
// and queues them in a first-word-fall-through FIFO drained by valid/ready.
module timestamp_capture #(
    parameter int unsigned INC          = 20,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CAPTURE_RISE = 1,
    parameter int unsigned CAPTURE_FALL = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [63:0] Timer,
    input  logic        Event,
    input  logic        Clear,
    output logic [63:0] Stamp,
    output logic        Stamp_Edge,
    output logic        Stamp_Valid,
    input  logic        Stamp_Ready,
    output logic        Overflow,
    output logic [15:0] Dropped
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned MW        = $clog2(SYNC_STAGES + 2);
    localparam logic [63:0] LATENCY   = 64'(SYNC_STAGES * INC);
    localparam logic [MW-1:0] MASK_INIT = MW'(SYNC_STAGES + 1);
    localparam logic        CAP_RISE  = (CAPTURE_RISE != 0);
    localparam logic        CAP_FALL  = (CAPTURE_FALL != 0);

    typedef struct packed {
        logic        rise;
        logic [63:0] ts;
    } entry_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [MW-1:0]          r_mask_cnt;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    entry_t                 r_mem [DEPTH];

    logic          w_s;
    logic          w_rise;
    logic          w_fall;
    logic          w_det;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;
    entry_t        w_wr_data;
    entry_t        w_head;

    // Edge detect on the synchronised pin; masked while the chain refills after reset.
    always_comb begin
        w_s    = r_sync[SYNC_STAGES-1];
        w_rise = w_s & ~r_prev;
        w_fall = ~w_s & r_prev;
        w_det  = (r_mask_cnt == '0) && ((w_rise && CAP_RISE) || (w_fall && CAP_FALL));
        w_wr_data.rise = w_s;
        w_wr_data.ts   = Timer - LATENCY;
    end

    // FIFO control; a full FIFO still accepts a write when the head pops in the same cycle.
    always_comb begin
        w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop    = Stamp_Valid & Stamp_Ready;
        w_wr     = w_det & (~w_full | w_pop);
        w_drop   = w_det & w_full & ~w_pop;
        w_wr_nxt = w_wr  ? r_wr_ptr + PW'(1) : r_wr_ptr;
        w_rd_nxt = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
        // The new head bypasses the array when it is the entry being written now.
        if (w_wr && (w_rd_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
            w_head = w_wr_data;
        end else begin
            w_head = r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync      <= '0;
            r_prev      <= 1'b0;
            r_mask_cnt  <= MASK_INIT;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            Stamp       <= '0;
            Stamp_Edge  <= 1'b0;
            Stamp_Valid <= 1'b0;
            Overflow    <= 1'b0;
            Dropped     <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], Event};
            r_prev   <= w_s;
            if (r_mask_cnt != '0) begin
                r_mask_cnt <= r_mask_cnt - MW'(1);
            end
            r_wr_ptr    <= w_wr_nxt;
            r_rd_ptr    <= w_rd_nxt;
            Stamp_Valid <= (w_wr_nxt != w_rd_nxt);
            if (w_wr_nxt != w_rd_nxt) begin
                Stamp      <= w_head.ts;
                Stamp_Edge <= w_head.rise;
            end
            // A drop in the same cycle as Clear restarts the count at one.
            if (w_drop) begin
                Overflow <= 1'b1;
                if (Clear) begin
                    Dropped <= 16'd1;
                end else if (Dropped != 16'hFFFF) begin
                    Dropped <= Dropped + 16'd1;
                end
            end else if (Clear) begin
                Overflow <= 1'b0;
                Dropped  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture: one rise-only instance and one instance
// capturing both edges, sharing clock, reset and the Timer bus.
module tb_timestamp_capture;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [63:0] timer;

    logic        ev_r, clr_r, rdy_r;
    logic [63:0] stamp_r;
    logic        edge_r, valid_r, ovf_r;
    logic [15:0] drop_r;

    logic        ev_b, clr_b, rdy_b;
    logic [63:0] stamp_b;
    logic        edge_b, valid_b, ovf_b;
    logic [15:0] drop_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q [10];
    logic [63:0] t4;
    logic [63:0] t_first;
    logic [63:0] t_fall;

    always #5 Clk = ~Clk;

    timestamp_capture dut_r (
        .Clk(Clk), .Reset(Reset), .Timer(timer), .Event(ev_r), .Clear(clr_r),
        .Stamp(stamp_r), .Stamp_Edge(edge_r), .Stamp_Valid(valid_r),
        .Stamp_Ready(rdy_r), .Overflow(ovf_r), .Dropped(drop_r)
    );

    timestamp_capture #(.CAPTURE_RISE(1), .CAPTURE_FALL(1)) dut_b (
        .Clk(Clk), .Reset(Reset), .Timer(timer), .Event(ev_b), .Clear(clr_b),
        .Stamp(stamp_b), .Stamp_Edge(edge_b), .Stamp_Valid(valid_b),
        .Stamp_Ready(rdy_b), .Overflow(ovf_b), .Dropped(drop_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; inputs and the Timer bus change 1 time unit after the edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
        timer = timer + 64'd20;
    endtask

    task automatic cycs(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        Reset = 1'b1;
        timer = '0;
        ev_r  = 1'b1; clr_r = 1'b0; rdy_r = 1'b0;
        ev_b  = 1'b0; clr_b = 1'b0; rdy_b = 1'b0;

        // Reset with Event already high: no spurious stamp after release
        cycs(3);
        Reset = 1'b0;
        check("reset_stamp", stamp_r, 64'd0);
        check("reset_edge", 64'(edge_r), 64'd0);
        check("reset_ovf", 64'(ovf_r), 64'd0);
        check("reset_dropped", 64'(drop_r), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("post_reset_valid", 64'(valid_r), 64'd0);
            cyc();
        end
        check("post_reset_valid_b", 64'(valid_b), 64'd0);

        // Single rising edge, Timer=1000, stamp = detect time - 40
        ev_r = 1'b0;
        cycs(4);
        check("fall_ignored_valid", 64'(valid_r), 64'd0);
        rdy_r = 1'b1;
        timer = 64'd1000;
        ev_r  = 1'b1;
        cycs(2);
        check("single_latency_valid", 64'(valid_r), 64'd0);
        cyc();
        check("single_valid", 64'(valid_r), 64'd1);
        check("single_stamp", stamp_r, 64'd1000);
        check("single_edge", 64'(edge_r), 64'd1);
        cyc();
        check("single_valid_one_cycle", 64'(valid_r), 64'd0);

        // Ten rising edges with Ready low: eight queued, two dropped
        rdy_r = 1'b0;
        ev_r  = 1'b0;
        cycs(3);
        for (int k = 0; k < 10; k++) begin
            exp_q[k] = timer;
            ev_r = 1'b1;
            cycs(2);
            ev_r = 1'b0;
            cycs(2);
        end
        check("full_ovf", 64'(ovf_r), 64'd1);
        check("full_dropped", 64'(drop_r), 64'd2);
        check("full_valid", 64'(valid_r), 64'd1);
        check("full_head_hold", stamp_r, exp_q[0]);
        check("full_head_edge", 64'(edge_r), 64'd1);

        // Full FIFO: pop and detect in the same cycle, write accepted
        t4   = timer;
        ev_r = 1'b1;
        cycs(2);
        rdy_r = 1'b1;
        cyc();
        rdy_r = 1'b0;
        check("popwr_dropped", 64'(drop_r), 64'd2);
        check("popwr_valid", 64'(valid_r), 64'd1);
        check("popwr_head", stamp_r, exp_q[1]);
        rdy_r = 1'b1;
        for (int k = 1; k < 8; k++) begin
            check("drain_valid", 64'(valid_r), 64'd1);
            check("drain_stamp", stamp_r, exp_q[k]);
            cyc();
        end
        check("drain_last_stamp", stamp_r, t4);
        check("drain_last_valid", 64'(valid_r), 64'd1);
        cyc();
        check("drain_empty", 64'(valid_r), 64'd0);
        rdy_r = 1'b0;
        ev_r  = 1'b0;

        // Clear alone resets the sticky flag and counter
        clr_r = 1'b1;
        cyc();
        clr_r = 1'b0;
        check("clear_ovf", 64'(ovf_r), 64'd0);
        check("clear_dropped", 64'(drop_r), 64'd0);

        // Timer near 2^64: stamp arithmetic wraps; falling edge captured on dut_b
        rdy_b = 1'b1;
        timer = 64'hFFFF_FFFF_FFFF_FFF0;
        ev_b  = 1'b1;
        cycs(3);
        check("wrap_valid", 64'(valid_b), 64'd1);
        check("wrap_stamp", stamp_b, 64'hFFFF_FFFF_FFFF_FFF0);
        check("wrap_edge", 64'(edge_b), 64'd1);
        cyc();
        check("wrap_valid_one_cycle", 64'(valid_b), 64'd0);
        t_fall = timer;
        ev_b   = 1'b0;
        cycs(3);
        check("fall_valid", 64'(valid_b), 64'd1);
        check("fall_stamp", stamp_b, t_fall);
        check("fall_edge", 64'(edge_b), 64'd0);
        cyc();
        check("fall_valid_one_cycle", 64'(valid_b), 64'd0);

        // Edge every cycle with Ready low: drop counter saturates
        rdy_b   = 1'b0;
        t_first = timer;
        for (int i = 0; i < 65550; i++) begin
            ev_b = ~ev_b;
            cyc();
        end
        cycs(4);
        check("sat_dropped", 64'(drop_b), 64'hFFFF);
        check("sat_ovf", 64'(ovf_b), 64'd1);
        check("sat_head_stamp", stamp_b, t_first);
        check("sat_head_edge", 64'(edge_b), 64'd1);
        clr_b = 1'b1;
        cyc();
        clr_b = 1'b0;
        check("sat_clear_dropped", 64'(drop_b), 64'd0);
        check("sat_clear_ovf", 64'(ovf_b), 64'd0);

        // Clear coincident with a drop: the drop wins
        ev_b = 1'b1;
        cycs(2);
        clr_b = 1'b1;
        cyc();
        clr_b = 1'b0;
        check("clr_drop_dropped", 64'(drop_b), 64'd1);
        check("clr_drop_ovf", 64'(ovf_b), 64'd1);

        // Reset mid-operation discards the queued stamps
        Reset = 1'b1;
        cycs(2);
        Reset = 1'b0;
        check("midreset_valid", 64'(valid_b), 64'd0);
        check("midreset_stamp", stamp_b, 64'd0);
        check("midreset_dropped", 64'(drop_b), 64'd0);
        check("midreset_ovf", 64'(ovf_b), 64'd0);
        cycs(6);
        check("midreset_masked", 64'(valid_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
